// File: rtl/tri_raster_ctrl.sv
// Triangle scan controller: latches one triangle, computes its clamped bounding box and
// signed area, walks the box with stepped edge functions and emits covered pixels as fragments.
module tri_raster_ctrl #(
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tri_valid,
  output logic        tri_ready,
  input  logic [15:0] x0,
  input  logic [15:0] y0,
  input  logic [15:0] x1,
  input  logic [15:0] y1,
  input  logic [15:0] x2,
  input  logic [15:0] y2,
  output logic [15:0] bc_px,
  output logic [15:0] bc_py,
  output logic [15:0] bc_x0,
  output logic [15:0] bc_y0,
  output logic [15:0] bc_x1,
  output logic [15:0] bc_y1,
  output logic [15:0] bc_x2,
  output logic [15:0] bc_y2,
  input  logic [15:0] bc_alpha,
  input  logic [15:0] bc_beta,
  input  logic [15:0] bc_gamma,
  output logic        frag_valid,
  input  logic        frag_ready,
  output logic [15:0] frag_x,
  output logic [15:0] frag_y,
  output logic [15:0] frag_alpha,
  output logic [15:0] frag_beta,
  output logic [15:0] frag_gamma,
  output logic        tri_done,
  output logic [19:0] frag_count
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SETUP_BOX  = 3'd1,
    SETUP_EDGE = 3'd2,
    SCAN       = 3'd3,
    DONE       = 3'd4
  } state_t;

  localparam logic signed [15:0] X_LIM = 16'(SCREEN_W - 1);
  localparam logic signed [15:0] Y_LIM = 16'(SCREEN_H - 1);

  function automatic logic signed [16:0] diff17(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
    diff17 = {a[15], a} - {b[15], b};
  endfunction

  function automatic logic signed [33:0] sx34(input logic signed [16:0] v);
    sx34 = {{17{v[16]}}, v};
  endfunction

  function automatic logic signed [33:0] mul17(input logic signed [16:0] a,
                                              input logic signed [16:0] b);
    mul17 = sx34(a) * sx34(b);
  endfunction

  function automatic logic signed [15:0] smin(input logic signed [15:0] a,
                                             input logic signed [15:0] b);
    smin = (a < b) ? a : b;
  endfunction

  function automatic logic signed [15:0] smax(input logic signed [15:0] a,
                                             input logic signed [15:0] b);
    smax = (a > b) ? a : b;
  endfunction

  function automatic logic le0(input logic signed [33:0] e);
    le0 = e[33] || (e == 34'sd0);
  endfunction

  state_t state_q, state_d;
  logic signed [15:0] vx0_q, vy0_q, vx1_q, vy1_q, vx2_q, vy2_q;
  logic signed [15:0] vx0_d, vy0_d, vx1_d, vy1_d, vx2_d, vy2_d;
  logic signed [15:0] xmin_q, xmax_q, ymin_q, ymax_q, xmin_d, xmax_d, ymin_d, ymax_d;
  logic signed [33:0] d_q, d_d;
  logic signed [16:0] sx0_q, sx1_q, sx2_q, sy0_q, sy1_q, sy2_q;
  logic signed [16:0] sx0_d, sx1_d, sx2_d, sy0_d, sy1_d, sy2_d;
  logic signed [33:0] e0_q, e1_q, e2_q, r0_q, r1_q, r2_q;
  logic signed [33:0] e0_d, e1_d, e2_d, r0_d, r1_d, r2_d;
  logic signed [15:0] cx_q, cy_q, cx_d, cy_d;
  logic        frag_valid_q, frag_valid_d;
  logic [15:0] frag_x_q, frag_y_q, frag_alpha_q, frag_beta_q, frag_gamma_q;
  logic [15:0] frag_x_d, frag_y_d, frag_alpha_d, frag_beta_d, frag_gamma_d;
  logic [19:0] frag_count_q, frag_count_d;
  logic        adv_s, inside_s, tri_done_s;

  // Coverage sign convention follows the winding: all edges >=0 for D>0, all <=0 for D<0.
  assign inside_s = d_q[33] ? (le0(e0_q) && le0(e1_q) && le0(e2_q))
                            : (!e0_q[33] && !e1_q[33] && !e2_q[33]);
  assign adv_s    = (state_q == SCAN) && (!frag_valid_q || frag_ready);

  // Next-state, setup arithmetic, scan stepping and fragment register control.
  always_comb begin
    state_d      = state_q;
    vx0_d = vx0_q; vy0_d = vy0_q; vx1_d = vx1_q; vy1_d = vy1_q; vx2_d = vx2_q; vy2_d = vy2_q;
    xmin_d = xmin_q; xmax_d = xmax_q; ymin_d = ymin_q; ymax_d = ymax_q;
    d_d = d_q;
    sx0_d = sx0_q; sx1_d = sx1_q; sx2_d = sx2_q; sy0_d = sy0_q; sy1_d = sy1_q; sy2_d = sy2_q;
    e0_d = e0_q; e1_d = e1_q; e2_d = e2_q; r0_d = r0_q; r1_d = r1_q; r2_d = r2_q;
    cx_d = cx_q; cy_d = cy_q;
    frag_x_d = frag_x_q; frag_y_d = frag_y_q;
    frag_alpha_d = frag_alpha_q; frag_beta_d = frag_beta_q; frag_gamma_d = frag_gamma_q;
    frag_count_d = frag_count_q;
    tri_done_s   = 1'b0;
    if (frag_valid_q && frag_ready) begin
      frag_valid_d = 1'b0;
    end else begin
      frag_valid_d = frag_valid_q;
    end

    case (state_q)
      IDLE: begin
        if (tri_valid) begin
          vx0_d = x0; vy0_d = y0; vx1_d = x1; vy1_d = y1; vx2_d = x2; vy2_d = y2;
          frag_count_d = 20'd0;
          state_d      = SETUP_BOX;
        end else begin
          state_d = IDLE;
        end
      end
      SETUP_BOX: begin
        xmin_d = smax(smin(smin(vx0_q, vx1_q), vx2_q), 16'sd0);
        xmax_d = smin(smax(smax(vx0_q, vx1_q), vx2_q), X_LIM);
        ymin_d = smax(smin(smin(vy0_q, vy1_q), vy2_q), 16'sd0);
        ymax_d = smin(smax(smax(vy0_q, vy1_q), vy2_q), Y_LIM);
        sx0_d  = diff17(vy1_q, vy2_q);
        sx1_d  = diff17(vy2_q, vy0_q);
        sx2_d  = diff17(vy0_q, vy1_q);
        sy0_d  = diff17(vx2_q, vx1_q);
        sy1_d  = diff17(vx0_q, vx2_q);
        sy2_d  = diff17(vx1_q, vx0_q);
        d_d    = mul17(sx0_d, diff17(vx0_q, vx2_q)) + mul17(sy0_d, diff17(vy0_q, vy2_q));
        state_d = SETUP_EDGE;
      end
      SETUP_EDGE: begin
        if ((d_q == 34'sd0) || (xmin_q > xmax_q) || (ymin_q > ymax_q)) begin
          state_d = DONE;
        end else begin
          e0_d = mul17(sx0_q, diff17(xmin_q, vx2_q)) + mul17(sy0_q, diff17(ymin_q, vy2_q));
          e1_d = mul17(sx1_q, diff17(xmin_q, vx2_q)) + mul17(sy1_q, diff17(ymin_q, vy2_q));
          e2_d = d_q - e0_d - e1_d;
          r0_d = e0_d; r1_d = e1_d; r2_d = e2_d;
          cx_d = xmin_q;
          cy_d = ymin_q;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (adv_s) begin
          if (inside_s) begin
            frag_valid_d = 1'b1;
            frag_x_d     = cx_q;
            frag_y_d     = cy_q;
            frag_alpha_d = bc_alpha;
            frag_beta_d  = bc_beta;
            frag_gamma_d = bc_gamma;
            frag_count_d = frag_count_q + 20'd1;
          end else begin
            frag_count_d = frag_count_q;
          end
          if (cx_q < xmax_q) begin
            cx_d = cx_q + 16'sd1;
            e0_d = e0_q + sx34(sx0_q);
            e1_d = e1_q + sx34(sx1_q);
            e2_d = e2_q + sx34(sx2_q);
          end else if (cy_q < ymax_q) begin
            cx_d = xmin_q;
            cy_d = cy_q + 16'sd1;
            r0_d = r0_q + sx34(sy0_q);
            r1_d = r1_q + sx34(sy1_q);
            r2_d = r2_q + sx34(sy2_q);
            e0_d = r0_q + sx34(sy0_q);
            e1_d = r1_q + sx34(sy1_q);
            e2_d = r2_q + sx34(sy2_q);
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = SCAN;
        end
      end
      DONE: begin
        // The last fragment must leave before the triangle is reported retired.
        if (!frag_valid_q || frag_ready) begin
          tri_done_s = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vx0_q <= 16'sd0; vy0_q <= 16'sd0; vx1_q <= 16'sd0;
      vy1_q <= 16'sd0; vx2_q <= 16'sd0; vy2_q <= 16'sd0;
      xmin_q <= 16'sd0; xmax_q <= 16'sd0; ymin_q <= 16'sd0; ymax_q <= 16'sd0;
      d_q <= 34'sd0;
      sx0_q <= 17'sd0; sx1_q <= 17'sd0; sx2_q <= 17'sd0;
      sy0_q <= 17'sd0; sy1_q <= 17'sd0; sy2_q <= 17'sd0;
      e0_q <= 34'sd0; e1_q <= 34'sd0; e2_q <= 34'sd0;
      r0_q <= 34'sd0; r1_q <= 34'sd0; r2_q <= 34'sd0;
      cx_q <= 16'sd0; cy_q <= 16'sd0;
      frag_valid_q <= 1'b0;
      frag_x_q <= 16'd0; frag_y_q <= 16'd0;
      frag_alpha_q <= 16'd0; frag_beta_q <= 16'd0; frag_gamma_q <= 16'd0;
      frag_count_q <= 20'd0;
    end else begin
      state_q <= state_d;
      vx0_q <= vx0_d; vy0_q <= vy0_d; vx1_q <= vx1_d;
      vy1_q <= vy1_d; vx2_q <= vx2_d; vy2_q <= vy2_d;
      xmin_q <= xmin_d; xmax_q <= xmax_d; ymin_q <= ymin_d; ymax_q <= ymax_d;
      d_q <= d_d;
      sx0_q <= sx0_d; sx1_q <= sx1_d; sx2_q <= sx2_d;
      sy0_q <= sy0_d; sy1_q <= sy1_d; sy2_q <= sy2_d;
      e0_q <= e0_d; e1_q <= e1_d; e2_q <= e2_d;
      r0_q <= r0_d; r1_q <= r1_d; r2_q <= r2_d;
      cx_q <= cx_d; cy_q <= cy_d;
      frag_valid_q <= frag_valid_d;
      frag_x_q <= frag_x_d; frag_y_q <= frag_y_d;
      frag_alpha_q <= frag_alpha_d; frag_beta_q <= frag_beta_d; frag_gamma_q <= frag_gamma_d;
      frag_count_q <= frag_count_d;
    end
  end

  assign tri_ready  = (state_q == IDLE);
  assign tri_done   = tri_done_s;
  assign frag_count = frag_count_q;
  assign frag_valid = frag_valid_q;
  assign frag_x     = frag_x_q;
  assign frag_y     = frag_y_q;
  assign frag_alpha = frag_alpha_q;
  assign frag_beta  = frag_beta_q;
  assign frag_gamma = frag_gamma_q;
  assign bc_px = cx_q;
  assign bc_py = cy_q;
  assign bc_x0 = vx0_q;
  assign bc_y0 = vy0_q;
  assign bc_x1 = vx1_q;
  assign bc_y1 = vy1_q;
  assign bc_x2 = vx2_q;
  assign bc_y2 = vy2_q;

endmodule

// File: tb/tb_tri_raster_ctrl.sv
// Directed bench for tri_raster_ctrl: table of triangles with hand-derived coverage,
// plus backpressure and mid-scan reset sequences.
module tb_tri_raster_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tri_valid = 1'b0;
  logic        tri_ready;
  logic [15:0] x0 = 16'd0, y0 = 16'd0, x1 = 16'd0, y1 = 16'd0, x2 = 16'd0, y2 = 16'd0;
  logic [15:0] bc_px, bc_py, bc_x0, bc_y0, bc_x1, bc_y1, bc_x2, bc_y2;
  logic [15:0] bc_alpha, bc_beta, bc_gamma;
  logic        frag_valid;
  logic        frag_ready = 1'b1;
  logic [15:0] frag_x, frag_y, frag_alpha, frag_beta, frag_gamma;
  logic        tri_done;
  logic [19:0] frag_count;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // Stand-in barycentric unit: a simple known function of the pixel under test.
  assign bc_alpha = bc_px + 16'd7;
  assign bc_beta  = bc_py ^ 16'h00F0;
  assign bc_gamma = bc_px - bc_py;

  tri_raster_ctrl dut (
    .clk(clk), .rst_n(rst_n), .tri_valid(tri_valid), .tri_ready(tri_ready),
    .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .bc_px(bc_px), .bc_py(bc_py),
    .bc_x0(bc_x0), .bc_y0(bc_y0), .bc_x1(bc_x1), .bc_y1(bc_y1), .bc_x2(bc_x2), .bc_y2(bc_y2),
    .bc_alpha(bc_alpha), .bc_beta(bc_beta), .bc_gamma(bc_gamma),
    .frag_valid(frag_valid), .frag_ready(frag_ready),
    .frag_x(frag_x), .frag_y(frag_y),
    .frag_alpha(frag_alpha), .frag_beta(frag_beta), .frag_gamma(frag_gamma),
    .tri_done(tri_done), .frag_count(frag_count)
  );

  typedef struct {
    int x0, y0, x1, y1, x2, y2;
    int bx0, bx1, by0, by1;   // expected clamped box
    int ox, oy, lim;          // covered iff (x-ox)+(y-oy) <= lim
    int cnt, lat;             // fragment count, accept-to-tri_done cycles
  } vec_t;

  vec_t vecs[6];

  function automatic logic [15:0] ea(int x);
    ea = 16'(x + 7);
  endfunction
  function automatic logic [15:0] eb(int y);
    eb = 16'(y) ^ 16'h00F0;
  endfunction
  function automatic logic [15:0] eg(int x, int y);
    eg = 16'(x - y);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic run_tri(input vec_t v, input int stall_after, input int stall_len,
                         input string tag);
    int ex[$];
    int ey[$];
    int n, w, busy_err, nstall, stall_left;
    bit stalling, done;
    for (int yy = v.by0; yy <= v.by1; yy++)
      for (int xx = v.bx0; xx <= v.bx1; xx++)
        if ((xx - v.ox) + (yy - v.oy) <= v.lim) begin
          ex.push_back(xx);
          ey.push_back(yy);
        end
    w = v.bx1 - v.bx0 + 1;
    n = 0; busy_err = 0; nstall = 0; stall_left = stall_len; stalling = 1'b0; done = 1'b0;

    @(posedge clk); #1;
    chk({tag, " ready_idle"}, 64'(tri_ready), 64'd1);
    x0 = 16'(v.x0); y0 = 16'(v.y0); x1 = 16'(v.x1);
    y1 = 16'(v.y1); x2 = 16'(v.x2); y2 = 16'(v.y2);
    tri_valid = 1'b1;
    frag_ready = 1'b1;
    @(posedge clk); #1;
    tri_valid = 1'b0;
    x0 = 16'h7777; y0 = 16'h7777; x1 = 16'h7777; y1 = 16'h7777; x2 = 16'h7777; y2 = 16'h7777;

    for (int k = 1; k <= 400 && !done; k++) begin
      @(negedge clk);
      if (tri_ready) busy_err++;
      if (frag_valid && frag_ready) begin
        if (n < ex.size()) begin
          chk({tag, " frag_xy"}, {32'd0, frag_x, frag_y}, {32'd0, 16'(ex[n]), 16'(ey[n])});
          chk({tag, " frag_w"}, {16'd0, frag_alpha, frag_beta, frag_gamma},
              {16'd0, ea(ex[n]), eb(ey[n]), eg(ex[n], ey[n])});
          if (stall_after == 0)
            chk({tag, " frag_cycle"}, 64'(k), 64'(4 + (ey[n] - v.by0) * w + (ex[n] - v.bx0)));
        end else begin
          chk({tag, " extra_frag"}, 64'(n), 64'(ex.size()));
        end
        n++;
      end else if (frag_valid && !frag_ready) begin
        nstall++;
        if (n < ex.size())
          chk({tag, " stall_hold"}, {32'd0, frag_x, frag_y}, {32'd0, 16'(ex[n]), 16'(ey[n])});
        else
          chk({tag, " stall_extra"}, 64'(n), 64'(ex.size()));
      end
      if (tri_done) begin
        done = 1'b1;
        if (stall_after == 0) chk({tag, " done_latency"}, 64'(k), 64'(v.lat));
        chk({tag, " frag_count"}, 64'(frag_count), 64'(v.cnt));
        chk({tag, " n_frags"}, 64'(n), 64'(ex.size()));
      end else begin
        @(posedge clk); #1;
        if (stall_after > 0 && n == stall_after && !stalling) stalling = 1'b1;
        if (stalling && stall_left > 0) begin
          frag_ready = 1'b0;
          stall_left--;
        end else begin
          frag_ready = 1'b1;
        end
      end
    end
    chk({tag, " done_seen"}, 64'(done), 64'd1);
    chk({tag, " busy_not_ready"}, 64'(busy_err), 64'd0);
    if (stall_after > 0) chk({tag, " stall_cycles"}, 64'(nstall), 64'(stall_len));
  endtask

  initial begin
    int dones, fvs;
    vecs[0] = '{0, 0, 4, 0, 0, 4,       0, 4, 0, 4,           0, 0, 4,      15, 28};
    vecs[1] = '{0, 0, 0, 4, 4, 0,       0, 4, 0, 4,           0, 0, 4,      15, 28};
    vecs[2] = '{0, 0, 2, 2, 4, 4,       0, 0, 0, 0,           0, 0, -1,     0,  3};
    vecs[3] = '{-2, -2, 3, -2, -2, 3,   0, 3, 0, 3,           -2, -2, 5,    3,  19};
    vecs[4] = '{-10, -10, -5, -10, -10, -5, 0, 0, 0, 0,       0, 0, -1,     0,  3};
    vecs[5] = '{636, 476, 644, 476, 636, 484, 636, 639, 476, 479, 636, 476, 8, 16, 19};

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst tri_ready", 64'(tri_ready), 64'd1);
    chk("rst frag_valid", 64'(frag_valid), 64'd0);
    chk("rst tri_done", 64'(tri_done), 64'd0);
    chk("rst frag_count", 64'(frag_count), 64'd0);
    chk("rst frag_bus", {frag_x, frag_y, frag_alpha, frag_gamma}, 64'd0);
    chk("rst bc_bus", {bc_px, bc_py, bc_x0, bc_y2}, 64'd0);

    for (int i = 0; i < 6; i++) run_tri(vecs[i], 0, 0, $sformatf("vec%0d", i));

    run_tri(vecs[0], 5, 10, "backpressure");

    // Abort a triangle in the middle of its scan with an asynchronous reset.
    @(posedge clk); #1;
    x0 = 16'd0; y0 = 16'd0; x1 = 16'd4; y1 = 16'd0; x2 = 16'd0; y2 = 16'd4;
    tri_valid = 1'b1;
    frag_ready = 1'b1;
    @(posedge clk); #1;
    tri_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst pre frag_valid", 64'(frag_valid), 64'd1);
    chk("midrst pre tri_ready", 64'(tri_ready), 64'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst frag_valid", 64'(frag_valid), 64'd0);
    chk("midrst tri_ready", 64'(tri_ready), 64'd1);
    chk("midrst frag_count", 64'(frag_count), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    dones = 0; fvs = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (tri_done) dones++;
      if (frag_valid) fvs++;
    end
    chk("midrst no tri_done", 64'(dones), 64'd0);
    chk("midrst no frag_valid", 64'(fvs), 64'd0);

    run_tri(vecs[3], 0, 0, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tri_raster_ctrl.md
# tri_raster_ctrl

Triangle scan controller that sequences the shared barycentric datapath. It accepts one screen-space triangle at a time and computes its clamped bounding box and signed area. It walks the box one pixel per cycle, tests coverage with incrementally stepped edge functions, and emits covered pixels as fragments. Each fragment carries the barycentric weights returned by the barycentric unit, which sits between this block and the fragment shader.

## Interface
- SCREEN_W, 640, screen width in pixels; x is clamped to [0, SCREEN_W-1]
- SCREEN_H, 480, screen height in pixels; y is clamped to [0, SCREEN_H-1]
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- tri_valid  in  1  triangle offered
- tri_ready  out  1  block is idle and can accept
- x0, y0, x1, y1, x2, y2  in  16 each  signed vertex coordinates, sampled on accept
- bc_px, bc_py  out  16 each  pixel under test, driven to the barycentric unit
- bc_x0 .. bc_y2  out  16 each  latched vertices, driven to the barycentric unit
- bc_alpha, bc_beta, bc_gamma  in  16 each  combinational weights for bc_px/bc_py
- frag_valid  out  1  fragment register full
- frag_ready  in  1  downstream accepts the fragment
- frag_x, frag_y  out  16 each  fragment pixel
- frag_alpha, frag_beta, frag_gamma  out  16 each  weights captured with the fragment
- tri_done  out  1  one-cycle pulse when a triangle is fully retired
- frag_count  out  20  fragments emitted for the last triangle; valid while tri_done is high

## Operation
- FSM states: IDLE, SETUP_BOX, SETUP_EDGE, SCAN, DONE.
- IDLE: tri_ready=1. On tri_valid&tri_ready, latch the vertices, clear frag_count and go to SETUP_BOX.
- SETUP_BOX:
  - xmin = max(min(x0,x1,x2), 0); xmax = min(max(x0,x1,x2), SCREEN_W-1); ymin and ymax likewise with SCREEN_H.
  - D = (y1-y2)(x0-x2) + (x2-x1)(y0-y2), signed 34-bit.
- SETUP_EDGE:
  - If D==0, xmin>xmax or ymin>ymax, go to DONE with no fragments.
  - Otherwise load edge values at (xmin, ymin): E0 = (y1-y2)(px-x2) + (x2-x1)(py-y2); E1 = (y2-y0)(px-x2) + (x0-x2)(py-y2); E2 = D-E0-E1. All are 34-bit signed.
  - Load row-start copies of E0..E2. Go to SCAN.
- SCAN: the current pixel (cx, cy) drives bc_px/bc_py.
  - Inside test: E0, E1 and E2 all ≥0 when D>0, or all ≤0 when D<0. Edges are inclusive.
  - Advance is allowed when !frag_valid | frag_ready.
  - On advance:
    - If the pixel is inside, load frag_* from cx, cy and bc_*, set frag_valid and increment frag_count.
    - Step: if cx<xmax, then cx++ and Ei += (yj-yk), the x step of each edge.
    - Else if cy<ymax, then cx=xmin, cy++, and each row-start value += its y step, copied into Ei.
    - Else go to DONE.
  - When advance is not allowed, all scan state holds.
- DONE: wait until the fragment register drains (frag_valid==0, or a handshake in this cycle). Then pulse tri_done for one cycle and go to IDLE.
- Fragment register:
  - A frag_valid&frag_ready handshake with no new load clears frag_valid.
  - A handshake and a load in the same cycle keep frag_valid=1 with the new data.
  - frag_* are stable while frag_valid&!frag_ready.
- Arithmetic: coordinate differences are 17-bit signed, products are 34-bit, no saturation. The bc_* weights are passed through unmodified.

## Timing
- Reset values: state=IDLE, tri_ready=1, frag_valid=0, tri_done=0, frag_count=0, all frag_* and bc_* outputs = 0.
- Reset is asynchronous. Asserting it mid-SCAN aborts the triangle immediately with no tri_done.
- Accept-to-first-SCAN-pixel: 3 cycles (SETUP_BOX, SETUP_EDGE, then SCAN).
- Throughput is 1 pixel/cycle with no backpressure. A W×H box takes W·H SCAN cycles.
- A fragment appears on frag_* the cycle after its pixel is evaluated.
- tri_done fires ≥1 cycle after the last SCAN cycle. A degenerate or empty triangle gives tri_done 3 cycles after accept.
- tri_ready=0 from the accept cycle +1 until IDLE is re-entered. There is no overlap between triangles.

## Test plan
- Reset: hold rst_n=0 for 3 cycles, then release → tri_ready=1, frag_valid=0, tri_done=0 and frag_count=0 from the first sampled edge.
- Triangle (0,0),(4,0),(0,4) with frag_ready=1 → D=16, 25 SCAN cycles. Exactly 15 fragments with x+y≤4, first (0,0), last (0,4), row-major order; tri_done with frag_count=15.
- Same triangle with vertices 1 and 2 swapped → D=-16, the identical 15 fragments.
- Collinear (0,0),(2,2),(4,4) → no frag_valid, tri_done 3 cycles after accept, frag_count=0.
- Clipped triangle (-2,-2),(3,-2),(-2,3) → box x,y 0..3 (16 SCAN cycles), fragments (0,0),(1,0),(0,1) only, frag_count=3.
- Backpressure: frag_ready=0 for 10 cycles after the 5th fragment of the 15-fragment triangle → frag_* stay stable, no loss or duplication, 15 fragments total. Then rst_n pulsed mid-SCAN → frag_valid=0, tri_ready=1, no tri_done.
